dac714_serial_tx: RTL and testbench

//   Serial transmitter for the DAC714 16-bit DAC. It sits directly downstream of the ramp generator
//   (rrg_round), capturing each dac_strobe/dac_out word and shifting it MSB-first over a 3-wire

---
 rtl/dac714_serial_tx_if.sv | 35 +++
 rtl/dac714_serial_tx.sv | 165 ++++++++++++++++
 tb/tb_dac714_serial_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dac714_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : dac714_serial_tx_if
// Description : Bus bundle between the ramp generator, the DAC714 serial
//               transmitter and the 3-wire DAC pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac714_serial_tx_if #(
  parameter int DAC_WIDTH = 16
);
  // Generator / control side
  logic                 enable;
  logic                 dac_strobe;
  logic [DAC_WIDTH-1:0] dac_in;
  logic                 ovr_clr;
  // DAC pins and status
  logic                 dac_sclk;
  logic                 dac_sdi;
  logic                 dac_nlatch;
  logic                 busy;
  logic [7:0]           ovr_cnt;

  // Upstream driver (generator / testbench)
  modport master (
    output enable, dac_strobe, dac_in, ovr_clr,
    input  dac_sclk, dac_sdi, dac_nlatch, busy, ovr_cnt
  );

  // Transmitter
  modport slave (
    input  enable, dac_strobe, dac_in, ovr_clr,
    output dac_sclk, dac_sdi, dac_nlatch, busy, ovr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dac714_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : dac714_serial_tx
// Description : DAC714 3-wire serial transmitter. Captures generator words
//               into a one-deep pending buffer and shifts them MSB-first on
//               SCLK/SDI, followed by an active-low nLATCH pulse. Words
//               overwritten in the pending buffer are counted (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module dac714_serial_tx #(
  parameter int DAC_WIDTH     = 16,
  parameter int CLK_DIV       = 1,
  parameter int LATCH_CYCLES  = 2,
  parameter int OFFSET_BINARY = 0
) (
  input  wire                      clk_slow,
  input  wire                      nReset,
  dac714_serial_tx_if.slave        dac_if
);

  // Shared down-counter covers both the SCLK half-period and the latch time.
  localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(DAC_WIDTH + 1);

  localparam logic [CNT_W-1:0] DIV_RELOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_RELOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD     = BIT_W'(DAC_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(1);
  // Flipping the sign bit turns two's complement into offset binary.
  localparam logic [DAC_WIDTH-1:0] MSB_FLIP =
    (OFFSET_BINARY != 0) ? {1'b1, {(DAC_WIDTH-1){1'b0}}} : '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [DAC_WIDTH-1:0] shreg_q,  shreg_d;
  logic [DAC_WIDTH-1:0] pend_q,   pend_d;
  logic                 pend_v_q, pend_v_d;
  logic [7:0]           ovr_q,    ovr_d;
  logic                 sclk_q, sdi_q, nlatch_q, busy_q;
  logic                 consume;
  logic                 accept;
  logic                 overrun;

  // Frame sequencer: load from pending, shift each bit low/high, then latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    consume  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_v_q && dac_if.enable) begin
          consume  = 1'b1;
          shreg_d  = pend_q ^ MSB_FLIP;
          bitcnt_d = BIT_LOAD;
          cnt_d    = DIV_RELOAD;
          state_d  = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == '0) begin
          cnt_d   = DIV_RELOAD;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == '0) begin
          shreg_d  = {shreg_q[DAC_WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q - 1'b1;
          if (bitcnt_q == BIT_LAST) begin
            cnt_d   = LATCH_RELOAD;
            state_d = LATCH;
          end else begin
            cnt_d   = DIV_RELOAD;
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending buffer and overrun counter; a word consumed this cycle is the old one.
  always_comb begin
    accept   = dac_if.dac_strobe && dac_if.enable;
    overrun  = accept && pend_v_q && !consume;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovr_d    = ovr_q;
    if (!dac_if.enable) begin
      pend_v_d = 1'b0;
    end else if (accept) begin
      pend_d   = dac_if.dac_in;
      pend_v_d = 1'b1;
    end else if (consume) begin
      pend_v_d = 1'b0;
    end
    if (dac_if.ovr_clr) begin
      ovr_d = '0;
    end else if (overrun && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // State, datapath and registered pin drivers decoded from the next state.
  always_ff @(posedge clk_slow) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= '0;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      nlatch_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovr_q    <= ovr_d;
      sclk_q   <= (state_d == SHIFT_HI);
      nlatch_q <= (state_d != LATCH);
      busy_q   <= (state_d != IDLE);
      // SDI only moves on entry to the low phase, so it is stable across the rise.
      if (state_d == SHIFT_LO) begin
        sdi_q <= shreg_d[DAC_WIDTH-1];
      end
    end
  end

  assign dac_if.dac_sclk   = sclk_q;
  assign dac_if.dac_sdi    = sdi_q;
  assign dac_if.dac_nlatch = nlatch_q;
  assign dac_if.busy       = busy_q;
  assign dac_if.ovr_cnt    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_dac714_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac714_serial_tx
// Description : Directed self-checking bench for dac714_serial_tx. Channel 0
//               uses default parameters, channel 1 uses OFFSET_BINARY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac714_serial_tx;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #50 clk = ~clk;

  dac714_serial_tx_if #(.DAC_WIDTH(16)) ifa ();
  dac714_serial_tx_if #(.DAC_WIDTH(16)) ifb ();

  dac714_serial_tx #(.DAC_WIDTH(16), .CLK_DIV(1), .LATCH_CYCLES(2), .OFFSET_BINARY(0)) u_dut_a (
    .clk_slow (clk),
    .nReset   (nReset),
    .dac_if   (ifa)
  );

  dac714_serial_tx #(.DAC_WIDTH(16), .CLK_DIV(1), .LATCH_CYCLES(2), .OFFSET_BINARY(1)) u_dut_b (
    .clk_slow (clk),
    .nReset   (nReset),
    .dac_if   (ifb)
  );

  // Pin monitor: reassembles frames from SDI at SCLK rises, measures pulse lengths.
  wire [1:0] m_sclk = {ifb.dac_sclk,   ifa.dac_sclk};
  wire [1:0] m_sdi  = {ifb.dac_sdi,    ifa.dac_sdi};
  wire [1:0] m_nl   = {ifb.dac_nlatch, ifa.dac_nlatch};
  wire [1:0] m_busy = {ifb.busy,       ifa.busy};

  logic [15:0] shift_r[2];
  int          bits[2], low_run[2], busy_run[2], idle_run[2];
  int          last_bits[2], last_low[2], last_busy[2], last_gap[2], nfr[2];
  logic [1:0]  p_sclk = 2'b00, p_sdi = 2'b00, p_nl = 2'b11, p_busy = 2'b00;
  int          viol = 0;
  logic [15:0] wq0[$];
  logic [15:0] wq1[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      shift_r[i] = '0; bits[i] = 0; low_run[i] = 0; busy_run[i] = 0; idle_run[i] = 0;
      last_bits[i] = 0; last_low[i] = 0; last_busy[i] = 0; last_gap[i] = 0; nfr[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!nReset) begin
        bits[i] = 0; low_run[i] = 0; busy_run[i] = 0; idle_run[i] = 0;
      end else begin
        if (m_sclk[i] && p_sclk[i] && (m_sdi[i] != p_sdi[i])) viol++;
        if (!m_nl[i] && m_sclk[i]) viol++;
        if (m_sclk[i] && !p_sclk[i]) begin
          shift_r[i] = {shift_r[i][14:0], m_sdi[i]};
          bits[i]++;
        end
        if (!m_nl[i]) low_run[i]++;
        if (m_nl[i] && !p_nl[i]) begin
          if (i == 0) wq0.push_back(shift_r[i]);
          else        wq1.push_back(shift_r[i]);
          last_bits[i] = bits[i];
          last_low[i]  = low_run[i];
          bits[i] = 0; low_run[i] = 0;
          nfr[i]++;
        end
        if (m_busy[i]) begin
          if (!p_busy[i]) begin last_gap[i] = idle_run[i]; idle_run[i] = 0; end
          busy_run[i]++;
        end else begin
          if (p_busy[i]) begin last_busy[i] = busy_run[i]; busy_run[i] = 0; end
          idle_run[i]++;
        end
      end
    end
    p_sclk = m_sclk; p_sdi = m_sdi; p_nl = m_nl; p_busy = m_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input int ch, input string tag, input logic [15:0] exp);
    logic [31:0] obs;
    obs = 32'hFFFF_FFFF;
    if (ch == 0) begin
      if (wq0.size() > 0) obs = {16'h0, wq0.pop_front()};
    end else begin
      if (wq1.size() > 0) obs = {16'h0, wq1.pop_front()};
    end
    check(tag, obs, {16'h0, exp});
  endtask

  // One-cycle strobe, driven just after an edge so the next edge samples it.
  task automatic strobe(input int ch, input logic [15:0] w);
    @(posedge clk); #1;
    if (ch == 0) begin ifa.dac_strobe = 1'b1; ifa.dac_in = w; end
    else         begin ifb.dac_strobe = 1'b1; ifb.dac_in = w; end
    @(posedge clk); #1;
    ifa.dac_strobe = 1'b0;
    ifb.dac_strobe = 1'b0;
  endtask

  task automatic wait_frames(input int ch, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while ((nfr[ch] < target) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check(tag, nfr[ch], target);
  endtask

  initial begin
    int lat;
    int rises;
    int base;
    ifa.enable = 1'b1; ifa.dac_strobe = 1'b0; ifa.dac_in = '0; ifa.ovr_clr = 1'b0;
    ifb.enable = 1'b1; ifb.dac_strobe = 1'b0; ifb.dac_in = '0; ifb.ovr_clr = 1'b0;
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1 nReset = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_sclk",   ifa.dac_sclk,   1'b0);
    check("rst_sdi",    ifa.dac_sdi,    1'b0);
    check("rst_nlatch", ifa.dac_nlatch, 1'b1);
    check("rst_busy",   ifa.busy,       1'b0);
    check("rst_ovr",    ifa.ovr_cnt,    8'd0);

    // 1: 0x8001 frame, latency, bit count, latch and busy lengths
    @(posedge clk); #1;
    ifa.dac_strobe = 1'b1; ifa.dac_in = 16'h8001;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      ifa.dac_strobe = 1'b0;
      lat++;
      if (ifa.dac_sclk) break;
    end
    check("t1_latency", lat, 3);
    wait_frames(0, 1, 60, "t1_frame_done");
    check_word(0, "t1_word", 16'h8001);
    check("t1_bits", last_bits[0], 16);
    check("t1_latch_len", last_low[0], 2);
    check("t1_busy_len", last_busy[0], 34);

    // 2: offset binary channel
    strobe(1, 16'h0000);
    wait_frames(1, 1, 60, "t2_frame0_done");
    check_word(1, "t2_word_0000", 16'h8000);
    strobe(1, 16'h7FFF);
    wait_frames(1, 2, 60, "t2_frame1_done");
    check_word(1, "t2_word_7fff", 16'hFFFF);

    // 3: second strobe during a frame goes out after one IDLE cycle
    strobe(0, 16'h1234);
    repeat (8) @(posedge clk);
    strobe(0, 16'hABCD);
    wait_frames(0, 3, 100, "t3_frames_done");
    check_word(0, "t3_word0", 16'h1234);
    check_word(0, "t3_word1", 16'hABCD);
    check("t3_gap", last_gap[0], 1);
    check("t3_ovr", ifa.ovr_cnt, 8'd0);

    // 4: overwrite of pending word, saturation, clear priority
    strobe(0, 16'h1111);
    repeat (4) @(posedge clk);
    strobe(0, 16'h2222);
    repeat (4) @(posedge clk);
    strobe(0, 16'h3333);
    wait_frames(0, 5, 120, "t4_frames_done");
    check_word(0, "t4_word0", 16'h1111);
    check_word(0, "t4_word1", 16'h3333);
    check("t4_ovr_one", ifa.ovr_cnt, 8'd1);
    @(posedge clk); #1;
    ifa.dac_strobe = 1'b1; ifa.dac_in = 16'h0F00;
    repeat (320) @(posedge clk);
    #1;
    check("t4_ovr_sat", ifa.ovr_cnt, 8'd255);
    ifa.ovr_clr = 1'b1;
    @(posedge clk); #1;
    ifa.ovr_clr = 1'b0; ifa.dac_strobe = 1'b0;
    check("t4_ovr_clr_prio", ifa.ovr_cnt, 8'd0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("t4_ovr_stays_0", ifa.ovr_cnt, 8'd0);
    check("t4_idle", ifa.busy, 1'b0);
    wq0.delete();

    // 5: reset while SCLK is high on the eighth bit
    strobe(0, 16'h9C3E);
    base = nfr[0];
    rises = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (ifa.dac_sclk) rises++;
      if (rises == 8) break;
    end
    check("t5_reached_bit", rises, 8);
    nReset = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_sclk",   ifa.dac_sclk,   1'b0);
    check("t5_rst_nlatch", ifa.dac_nlatch, 1'b1);
    check("t5_rst_busy",   ifa.busy,       1'b0);
    nReset = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t5_no_latch", nfr[0], base);
    strobe(0, 16'h5A5A);
    wait_frames(0, base + 1, 60, "t5_frame_done");
    check_word(0, "t5_word", 16'h5A5A);

    // 6: disable mid-frame drops pending word and ignores strobes
    base = nfr[0];
    strobe(0, 16'h0F0F);
    repeat (3) @(posedge clk);
    strobe(0, 16'hF0F0);
    repeat (3) @(posedge clk);
    #1 ifa.enable = 1'b0;
    strobe(0, 16'h1357);
    wait_frames(0, base + 1, 60, "t6_frame_done");
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t6_no_extra", nfr[0], base + 1);
    check_word(0, "t6_word", 16'h0F0F);
    check("t6_busy", ifa.busy, 1'b0);
    check("t6_ovr", ifa.ovr_cnt, 8'd0);
    @(posedge clk); #1 ifa.enable = 1'b1;
    strobe(0, 16'h00FF);
    wait_frames(0, base + 2, 60, "t6_reenable_done");
    check_word(0, "t6_word_00ff", 16'h00FF);

    check("pin_protocol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
